// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared constants for the seven-segment scanner.
//   SEG_W          : segment vector width ({a,b,c,d,e,f,g})
//   SEG_BLANK      : all segments off (active-low)
//   HEX_SEG_TABLE  : active-low segment pattern per hex nibble, index = nibble
// -----------------------------------------------------------------------------
package sevenseg_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   // Packed array: element 15 is the leftmost entry, element 0 the rightmost.
   localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
      7'b0111000,   // F
      7'b0110000,   // E
      7'b1000010,   // d
      7'b0110001,   // C
      7'b1100000,   // b
      7'b0001000,   // A
      7'b0000100,   // 9
      7'b0000000,   // 8
      7'b0001111,   // 7
      7'b0100000,   // 6
      7'b0100100,   // 5
      7'b1001100,   // 4
      7'b0000110,   // 3
      7'b0010010,   // 2
      7'b1001111,   // 1
      7'b0000001    // 0
   };

endpackage

// File: rtl/sevenseg_decode.sv
// -----------------------------------------------------------------------------
// sevenseg_decode
// Purely combinational hex nibble to active-low seven-segment pattern.
//   i_nibble : hex digit 0..F
//   o_seg    : {a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
module sevenseg_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0]       i_nibble,
   output logic [SEG_W-1:0] o_seg
);

   assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// sevenseg_scanner
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//   clk, rstn  : clock, asynchronous active-low reset
//   i_value    : hex nibbles, nibble k shown on digit k
//   i_dp       : decimal-point request per digit
//   i_load     : one-cycle strobe capturing i_value / i_dp into pending
//   i_lzb      : leading-zero blanking enable, captured at each slot start
//   i_bright   : PWM brightness, 0 dimmest .. 15 always on
//   o_an       : active-low anodes, at most one low
//   o_seg      : active-low segments {a..g}
//   o_dp       : active-low decimal point
//   o_frame    : one-cycle pulse when the shadow register takes pending
// Pending data only reaches the display at a frame wrap, so a frame never
// mixes digits from two different loads.
// -----------------------------------------------------------------------------
module sevenseg_scanner
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 100000
)
(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [4*NUM_DIGITS-1:0] i_value,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic                    i_load,
   input  logic                    i_lzb,
   input  logic [3:0]              i_bright,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic [SEG_W-1:0]        o_seg,
   output logic                    o_dp,
   output logic                    o_frame
);

   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
   logic [DIG_W-1:0]        digit_q,    digit_d;
   logic [3:0]              pwm_q,      pwm_d;
   logic                    lzb_q,      lzb_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q,  pend_dp_d;
   logic [4*NUM_DIGITS-1:0] shad_val_q, shad_val_d;
   logic [NUM_DIGITS-1:0]   shad_dp_q,  shad_dp_d;
   logic [NUM_DIGITS-1:0]   an_q,       an_d;
   logic [SEG_W-1:0]        seg_q,      seg_d;
   logic                    dp_q,       dp_d;
   logic                    frame_q,    frame_d;

   logic                    slot_end;
   logic                    frame_wrap;
   logic [3:0]              cur_nib;
   logic [SEG_W-1:0]        cur_pat;
   logic [DIG_W-1:0]        top_idx;
   logic                    blank;
   logic                    lit;

   sevenseg_decode u_decode (
      .i_nibble (cur_nib),
      .o_seg    (cur_pat)
   );

   assign slot_end   = (slot_cnt_q == SLOT_LAST);
   assign frame_wrap = slot_end && (digit_q == DIG_LAST);
   assign cur_nib    = shad_val_q[4*int'(digit_q) +: 4];

   // Highest digit holding a nonzero nibble; digits above it are leading zeros.
   always_comb begin
      top_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (shad_val_q[4*i +: 4] != 4'd0) top_idx = DIG_W'(i);
      end
   end

   always_comb begin
      slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
      digit_d    = digit_q;
      if (slot_end) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
      pwm_d      = pwm_q + 4'd1;
      lzb_d      = slot_end ? i_lzb : lzb_q;

      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      if (i_load) begin
         pend_val_d = i_value;
         pend_dp_d  = i_dp;
      end

      // The shadow reads the registered pending, so a strobe landing on the
      // wrap cycle is deferred to the following frame.
      shad_val_d = shad_val_q;
      shad_dp_d  = shad_dp_q;
      if (frame_wrap) begin
         shad_val_d = pend_val_q;
         shad_dp_d  = pend_dp_q;
      end
   end

   // Anode, segments and dp are all derived from the same digit index and
   // registered together, so a digit never shows its neighbour's pattern.
   always_comb begin
      blank   = lzb_q && (digit_q > top_idx);
      lit     = !blank && (pwm_q <= i_bright);
      an_d    = '1;
      if (lit) an_d[digit_q] = 1'b0;
      seg_d   = blank ? SEG_BLANK : cur_pat;
      dp_d    = ~(shad_dp_q[digit_q] & lit);
      frame_d = frame_wrap;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_cnt_q <= '0;
         digit_q    <= '0;
         pwm_q      <= '0;
         lzb_q      <= 1'b0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         shad_val_q <= '0;
         shad_dp_q  <= '0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
         frame_q    <= 1'b0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         digit_q    <= digit_d;
         pwm_q      <= pwm_d;
         lzb_q      <= lzb_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         shad_val_q <= shad_val_d;
         shad_dp_q  <= shad_dp_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         frame_q    <= frame_d;
      end
   end

   assign o_an    = an_q;
   assign o_seg   = seg_q;
   assign o_dp    = dp_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scanner
// Drives a NUM_DIGITS=8 / PRESCALE=4 scanner cycle by cycle against a model
// that derives slot, digit and PWM phase from the number of clock edges since
// reset, plus a PRESCALE=16 instance used for the brightness duty count.
// -----------------------------------------------------------------------------
module tb_sevenseg_scanner;

   localparam int N   = 8;
   localparam int P   = 4;
   localparam int P16 = 16;
   localparam int FR  = N * P;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic [4*N-1:0] i_value;
   logic [N-1:0]   i_dp;
   logic           i_load;
   logic           i_lzb;
   logic [3:0]     i_bright;
   logic [N-1:0]   o_an,  o_an16;
   logic [6:0]     o_seg, o_seg16;
   logic           o_dp,  o_dp16;
   logic           o_frame, o_frame16;

   sevenseg_scanner #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
      .clk(clk), .rstn(rstn), .i_value(i_value), .i_dp(i_dp), .i_load(i_load),
      .i_lzb(i_lzb), .i_bright(i_bright), .o_an(o_an), .o_seg(o_seg),
      .o_dp(o_dp), .o_frame(o_frame)
   );

   sevenseg_scanner #(.NUM_DIGITS(N), .PRESCALE(P16)) dut16 (
      .clk(clk), .rstn(rstn), .i_value(i_value), .i_dp(i_dp), .i_load(i_load),
      .i_lzb(i_lzb), .i_bright(i_bright), .o_an(o_an16), .o_seg(o_seg16),
      .o_dp(o_dp16), .o_frame(o_frame16)
   );

   // ---------------- reference model ----------------
   logic [6:0] hex_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int unsigned    e;          // clock edges since reset release
   logic [4*N-1:0] m_pend, m_shad;
   logic [N-1:0]   m_pend_dp, m_shad_dp;
   logic           m_lzb;

   // {an[8], seg[7], dp, frame}
   logic [16:0] exp_q [$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      e         = 0;
      m_pend    = '0;
      m_shad    = '0;
      m_pend_dp = '0;
      m_shad_dp = '0;
      m_lzb     = 1'b0;
   endtask

   // Outputs expected one edge from now, from the display state reached after e edges.
   function automatic logic [16:0] model_out();
      int k, pwm, top;
      logic blank, lit, dp, frame;
      logic [N-1:0] an;
      logic [6:0] seg;
      k   = int'((e / P) % N);
      pwm = int'(e % 16);
      top = 0;
      for (int i = 0; i < N; i++) if (m_shad[4*i +: 4] != 4'd0) top = i;
      blank = m_lzb && (k > top);
      lit   = !blank && (pwm <= int'(i_bright));
      an    = '1;
      if (lit) an[k] = 1'b0;
      seg   = blank ? 7'b1111111 : hex_tab[m_shad[4*k +: 4]];
      dp    = !(m_shad_dp[k] && lit);
      frame = ((e % FR) == FR - 1);
      return {an, seg, dp, frame};
   endfunction

   task automatic model_advance();
      if ((e % FR) == FR - 1) begin
         m_shad    = m_pend;
         m_shad_dp = m_pend_dp;
      end
      if ((e % P) == P - 1) m_lzb = i_lzb;
      if (i_load) begin
         m_pend    = i_value;
         m_pend_dp = i_dp;
      end
      e++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      logic [16:0] got;
      exp_q.push_back(model_out());
      model_advance();
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check("an", o_an, got[16:9]);
      if (got[16:9] != '1) check("seg", o_seg, got[8:2]);
      check("dp", o_dp, got[1]);
      check("frame", o_frame, got[0]);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load(input logic [4*N-1:0] v, input logic [N-1:0] dp);
      i_value = v;
      i_dp    = dp;
      i_load  = 1'b1;
      step();
      i_load  = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!o_frame && n < 2 * FR);
      check(tag, o_frame, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [4:0]  hi_lit;
      int          cnt [N];
      int          nlow;

      i_value  = '0;
      i_dp     = '0;
      i_load   = 1'b0;
      i_lzb    = 1'b0;
      i_bright = 4'd15;
      model_reset();

      #2 rstn = 1'b0;
      #2;
      check("rst_an",    o_an,    8'hFF);
      check("rst_seg",   o_seg,   7'h7F);
      check("rst_dp",    o_dp,    1);
      check("rst_frame", o_frame, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;

      // Idle scan after reset: digits walk FE..7F, all showing 0.
      step();
      check("first_an",  o_an,  8'hFE);
      check("first_seg", o_seg, 7'b0000001);
      steps(70);

      // Mid-frame load stays hidden until the next frame.
      steps(5);
      load(32'h89AB_CDEF, 8'h00);
      wait_frame("frame_after_load");
      step();
      check("load_d0_an",  o_an,  8'hFE);
      check("load_d0_seg", o_seg, 7'b0111000);
      steps(7 * P);
      check("load_d7_an",  o_an,  8'h7F);
      check("load_d7_seg", o_seg, 7'b0000000);
      steps(40);

      // Leading-zero blanking.
      i_lzb = 1'b1;
      load(32'h0000_0120, 8'h00);
      steps(2 * FR + 5);
      hi_lit = '0;
      for (int i = 0; i < FR; i++) begin
         step();
         hi_lit |= ~o_an[7:3];
      end
      check("lzb_hi_dark", hi_lit, 5'd0);
      i_lzb = 1'b0;
      steps(10);

      // Load strobe landing on the frame-wrap cycle.
      load(32'h0000_0002, 8'h00);
      for (int n = 0; n < 2 * FR && (e % FR) != FR - 1; n++) step();
      check("wrap_aligned", e % FR, FR - 1);
      load(32'h0000_0001, 8'h00);
      check("wrap_frame", o_frame, 1);
      step();
      check("wrap_old_seg", o_seg, 7'b0010010);
      wait_frame("frame_after_wrap");
      step();
      check("wrap_new_seg", o_seg, 7'b1001111);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         i_load   = ($urandom_range(0, 15) == 0);
         i_value  = $urandom >> $urandom_range(0, 31);
         i_dp     = 8'($urandom);
         i_bright = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) i_lzb = ~i_lzb;
         step();
      end
      i_load   = 1'b0;
      i_lzb    = 1'b0;
      i_bright = 4'd15;

      // Asynchronous reset mid-slot with every dp lit, pending load discarded.
      load(32'h1234_5678, 8'hFF);
      steps(2 * FR + 1);
      load(32'hFFFF_FFFF, 8'hFF);
      step();
      #2 rstn = 1'b0;
      #1;
      check("arst_an",    o_an,    8'hFF);
      check("arst_dp",    o_dp,    1);
      check("arst_seg",   o_seg,   7'h7F);
      check("arst_frame", o_frame, 0);
      model_reset();
      i_bright = 4'd3;
      @(negedge clk) rstn = 1'b1;

      // Brightness 3: each anode of the PRESCALE=16 instance low 4 cycles per slot.
      step();
      for (int j = 0; j < N; j++) cnt[j] = 0;
      for (int i = 0; i < N * P16; i++) begin
         step();
         nlow = $countones(~o_an16);
         check("b16_one_hot", (nlow <= 1), 1);
         for (int j = 0; j < N; j++) if (!o_an16[j]) cnt[j]++;
      end
      for (int j = 0; j < N; j++) check($sformatf("b16_duty%0d", j), cnt[j], 4);
      steps(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sevenseg_scanner.md
SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (range 1..16).
REQ-002 SHALL have parameter PRESCALE, default 100000, clk cycles per digit slot (minimum 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_value  input  4*NUM_DIGITS  hex nibbles; nibble k shown on digit k.
REQ-006 SHALL have port i_dp  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-007 SHALL have port i_load  input  1  one-cycle strobe capturing i_value and i_dp.
REQ-008 SHALL have port i_lzb  input  1  leading-zero blanking enable, sampled each slot start.
REQ-009 SHALL have port i_bright  input  4  brightness, 0 dimmest, 15 full.
REQ-010 SHALL have port o_an  output  NUM_DIGITS  digit anodes, active-low, at most one low.
REQ-011 SHALL have port o_seg  output  7  {a,b,c,d,e,f,g}, active-low.
REQ-012 SHALL have port o_dp  output  1  decimal point, active-low.
REQ-013 SHALL have port o_frame  output  1  one-cycle pulse at each frame start.

Function
REQ-014 SHALL count slot cycles 0..PRESCALE-1; at PRESCALE-1 wrap to 0 and advance digit index k, NUM_DIGITS-1 wrapping to 0.
REQ-015 SHALL hold a pending register written on i_load (last strobe wins) and a display shadow register.
REQ-016 SHALL copy pending to shadow on the cycle k wraps NUM_DIGITS-1->0 and pulse o_frame that same cycle.
REQ-017 SHALL, when i_load coincides with a frame wrap, give shadow the pre-strobe pending contents; new data appears next frame.
REQ-018 SHALL decode the shadow nibble of digit k to the hex pattern: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-019 SHALL, with i_lzb=1, blank (anode high) every digit above the highest nonzero shadow nibble; digit 0 is never blanked; all-zero shows a single 0.
REQ-020 SHALL run a free 4-bit PWM counter and drive o_an[k] low only while pwm <= i_bright; i_bright=15 gives constant on.
REQ-021 SHALL drive o_dp low when shadow dp bit k is 1 and digit k is unblanked and PWM-enabled.
REQ-022 SHALL register o_an, o_seg, o_dp, o_frame: change exactly one cycle after the internal state that produces them.
REQ-023 SHALL update o_seg and o_an in the same cycle so no digit ever shows the neighbour's pattern.

Reset
REQ-024 SHALL on rstn low immediately set o_an all-ones, o_seg 7'b1111111, o_dp 1, o_frame 0.
REQ-025 SHALL on reset clear slot counter, PWM counter, k to 0, pending and shadow to zero.
REQ-026 SHALL after reset release show digit 0 from the first cycle, value 0 unless loaded; reset mid-frame discards pending load.

Structure
REQ-027 SHALL place the hex-to-segment table, SEG_BLANK constant and segment-width constant in package sevenseg_pkg.
REQ-028 SHALL instantiate combinational sub-module sevenseg_decode (nibble in, 7-bit pattern out); all counters stay in sevenseg_scanner.

Verification (NUM_DIGITS=8, PRESCALE=4, i_bright=15)
REQ-029 SHALL cover: reset release, no load -> o_an cycles FE,FD,...,7F every 4 cycles, o_seg=0000001, o_frame every 32 cycles.
REQ-030 SHALL cover: i_load value 32'h89ABCDEF mid-frame -> unchanged until next o_frame, then digit 0 shows F (0111000), digit 7 shows 8.
REQ-031 SHALL cover: i_lzb=1, value 32'h0000_0120 -> digits 0..2 lit (0,2,1), o_an bits 3..7 stay high.
REQ-032 SHALL cover: i_load on frame-wrap cycle with 32'h1, pending previously 32'h2 -> this frame shows 2, next frame 1.
REQ-033 SHALL cover: i_bright=3 -> each anode low exactly 4 of every 16 cycles in its slot when PRESCALE=16.
REQ-034 SHALL cover: rstn asserted mid-slot with i_dp=8'hFF -> o_an=FF, o_dp=1 same cycle, asynchronously.
